// File: rtl/muxnx1_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muxnx1_scan : CH:1 registered mux with manual select or auto-scan    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module muxnx1_scan #(
    parameter int  WIDTH = 1,
    parameter int  CH    = 4,
    parameter int  DWELL = 100,
    localparam int SEL_W = $clog2(CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH*WIDTH-1:0]   in,
    input  logic                  mode,
    input  logic                  en,
    input  logic [SEL_W-1:0]      sel_in,
    output logic [WIDTH-1:0]      out,
    output logic [SEL_W-1:0]      sel_out,
    output logic                  wrap
);

    localparam int CNT_W = $clog2(DWELL + 1);

    localparam logic [SEL_W:0]   c_CH_EXT   = (SEL_W + 1)'(CH);
    localparam logic [SEL_W-1:0] c_CH_LAST  = SEL_W'(CH - 1);
    localparam logic [SEL_W-1:0] c_SEL_ONE  = SEL_W'(1);
    localparam logic [CNT_W-1:0] c_DWELL_M1 = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] w_ch [CH];
    logic [SEL_W-1:0] w_sel_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_wrap_nxt;

    logic [WIDTH-1:0] r_out;
    logic [SEL_W-1:0] r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wrap;

    for (genvar k = 0; k < CH; k++) begin : g_unpack
        assign w_ch[k] = in[k*WIDTH +: WIDTH];
    end

    always_comb begin
        w_sel_nxt  = r_sel;
        w_cnt_nxt  = r_cnt;
        w_wrap_nxt = 1'b0;
        if (!mode) begin
            w_cnt_nxt = '0;
            // An out-of-range manual select keeps the current channel.
            if ({1'b0, sel_in} < c_CH_EXT) begin
                w_sel_nxt = sel_in;
            end
        end else if (en) begin
            if (r_cnt == c_DWELL_M1) begin
                w_cnt_nxt = '0;
                if (r_sel == c_CH_LAST) begin
                    w_sel_nxt  = '0;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_sel_nxt = r_sel + c_SEL_ONE;
                end
            end else begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
        end
    end

    // Data and select load on the same edge so they always agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out  <= '0;
            r_sel  <= '0;
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_out  <= w_ch[w_sel_nxt];
            r_sel  <= w_sel_nxt;
            r_cnt  <= w_cnt_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign out     = r_out;
    assign sel_out = r_sel;
    assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_muxnx1_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_muxnx1_scan : directed table-driven bench for muxnx1_scan         |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_muxnx1_scan;

    localparam int WIDTH = 1;
    localparam int CH    = 4;
    localparam int DWELL = 4;
    localparam logic [3:0] c_IN = 4'b0101;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] in  = c_IN;
    logic       mode = 1'b0;
    logic       en   = 1'b0;
    logic [1:0] sel_in = 2'd0;
    logic       out;
    logic [1:0] sel_out;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    muxnx1_scan #(.WIDTH(WIDTH), .CH(CH), .DWELL(DWELL)) dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .mode    (mode),
        .en      (en),
        .sel_in  (sel_in),
        .out     (out),
        .sel_out (sel_out),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic       en;
        logic [1:0] sel_in;
        logic       exp_out;
        logic [1:0] exp_sel;
        logic       exp_wrap;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic m, input logic e, input logic [1:0] s,
                                input logic eo, input logic [1:0] es, input logic ew,
                                input string n);
        vec_t v;
        v.mode = m; v.en = e; v.sel_in = s;
        v.exp_out = eo; v.exp_sel = es; v.exp_wrap = ew; v.name = n;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all(input string tag, input logic eo, input logic [1:0] es,
                             input logic ew);
        chk({tag, ".out"}, 32'(out), 32'(eo));
        chk({tag, ".sel_out"}, 32'(sel_out), 32'(es));
        chk({tag, ".wrap"}, 32'(wrap), 32'(ew));
    endtask

    // Reset asserted and released at falling edges; next rising edge is the first live one.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       tog;
        logic [1:0] ch_of [0:3];
        ch_of[0] = 2'd0; ch_of[1] = 2'd1; ch_of[2] = 2'd2; ch_of[3] = 2'd3;

        // T2 manual: three clocks per select, ch data 1,0,1,0
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 3; k++) begin
                vecs.push_back(mk(1'b0, 1'b0, ch_of[s], c_IN[s], ch_of[s], 1'b0, "T2"));
            end
        end
        // T3 auto from reset: edge i selects channel (i/4)%4; wrap on the 16th edge
        for (int i = 1; i <= 17; i++) begin
            vecs.push_back(mk(1'b1, 1'b1, 2'd0, c_IN[(i/4)%4], ch_of[(i/4)%4],
                              (i == 16) ? 1'b1 : 1'b0, "T3"));
        end

        do_reset();
        #1;
        check_all("reset_init", 1'b0, 2'd0, 1'b0);

        // T2 (vectors 0..11)
        for (int i = 0; i < 12; i++) begin
            mode = vecs[i].mode; en = vecs[i].en; sel_in = vecs[i].sel_in;
            tick(1);
            check_all($sformatf("%s[%0d]", vecs[i].name, i),
                      vecs[i].exp_out, vecs[i].exp_sel, vecs[i].exp_wrap);
        end

        // T1: move to channel 2 then assert rst mid-cycle, expect immediate clear
        mode = 1'b0; sel_in = 2'd2;
        tick(1);
        check_all("T1.pre", 1'b1, 2'd2, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all("T1.async", 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        sel_in = 2'd0;

        // T3 (vectors 12..28) from a fresh reset
        do_reset();
        for (int i = 12; i < vecs.size(); i++) begin
            mode = vecs[i].mode; en = vecs[i].en; sel_in = vecs[i].sel_in;
            tick(1);
            check_all($sformatf("%s[%0d]", vecs[i].name, i - 12),
                      vecs[i].exp_out, vecs[i].exp_sel, vecs[i].exp_wrap);
        end

        // T4 freeze on channel 2 with cnt=1, toggling in[2]
        mode = 1'b0; en = 1'b0; sel_in = 2'd0;
        do_reset();
        mode = 1'b1; en = 1'b1;
        tick(9);
        check_all("T4.start", 1'b1, 2'd2, 1'b0);
        en = 1'b0;
        tog = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tog = ~tog;
            in = {c_IN[3], c_IN[2] ^ tog, c_IN[1:0]};
            tick(1);
            check_all($sformatf("T4.frz[%0d]", i), c_IN[2] ^ tog, 2'd2, 1'b0);
        end
        in = c_IN;
        en = 1'b1;
        tick(2);
        check_all("T4.resume", 1'b1, 2'd2, 1'b0);
        tick(1);
        check_all("T4.step", 1'b0, 2'd3, 1'b0);

        // T5 auto on channel 1, switch to manual sel 3, then back to auto
        mode = 1'b0; en = 1'b0;
        do_reset();
        mode = 1'b1; en = 1'b1;
        tick(5);
        check_all("T5.ch1", 1'b0, 2'd1, 1'b0);
        mode = 1'b0; sel_in = 2'd3;
        tick(1);
        check_all("T5.man", 1'b0, 2'd3, 1'b0);
        mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_all($sformatf("T5.dwell[%0d]", i), 1'b0, 2'd3, 1'b0);
        end
        tick(1);
        check_all("T5.wrap", 1'b1, 2'd0, 1'b1);
        tick(1);
        check_all("T5.after", 1'b1, 2'd0, 1'b0);

        // T6 reset pulse at cnt=2 on channel 2
        mode = 1'b0; en = 1'b0; sel_in = 2'd0;
        do_reset();
        mode = 1'b1; en = 1'b1;
        tick(10);
        check_all("T6.pre", 1'b1, 2'd2, 1'b0);
        rst = 1'b1;
        #1;
        check_all("T6.async", 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_all($sformatf("T6.dwell[%0d]", i), 1'b1, 2'd0, 1'b0);
        end
        tick(1);
        check_all("T6.step", 1'b0, 2'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
